// File: rtl/seg_pwm_pkg.sv
// Shared constants for the seven-segment PWM decoder: segment indices, widths
// and the chase order that the tracker follows around the display.
package seg_pwm_pkg;

  localparam int NUM_SEGS  = 7;
  localparam int SEG_W     = 3;
  localparam int STEP_W    = 3;
  localparam int NUM_STEPS = 1 << STEP_W;

  typedef logic [SEG_W-1:0]  seg_idx_t;
  typedef logic [STEP_W-1:0] step_t;

  localparam seg_idx_t SEG_A = 3'd0;
  localparam seg_idx_t SEG_B = 3'd1;
  localparam seg_idx_t SEG_C = 3'd2;
  localparam seg_idx_t SEG_D = 3'd3;
  localparam seg_idx_t SEG_E = 3'd4;
  localparam seg_idx_t SEG_F = 3'd5;
  localparam seg_idx_t SEG_G = 3'd6;

  // Step k of the chase lights CHASE_TABLE[k*SEG_W +: SEG_W]; g appears twice.
  localparam logic [NUM_STEPS*SEG_W-1:0] CHASE_TABLE =
    {SEG_F, SEG_G, SEG_C, SEG_D, SEG_E, SEG_G, SEG_B, SEG_A};

  function automatic seg_idx_t chase_seg(input step_t s);
    return CHASE_TABLE[s*SEG_W +: SEG_W];
  endfunction

  function automatic step_t first_step_of(input seg_idx_t seg);
    step_t result = '0;
    for (int k = NUM_STEPS - 1; k >= 0; k--) begin
      if (chase_seg(step_t'(k)) == seg) result = step_t'(k);
    end
    return result;
  endfunction

endpackage

// File: rtl/seg_duty_counter.sv
// Per-segment duty accumulator: counts lit samples across one window and,
// on capture, presents the total including the current sample while restarting.
module seg_duty_counter
  import seg_pwm_pkg::*;
#(
  parameter int WINDOW_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_sample,
  input  logic                  i_capture,
  output logic [WINDOW_WIDTH:0] o_total
);

  localparam logic [WINDOW_WIDTH:0] FULL = {1'b1, {WINDOW_WIDTH{1'b0}}};

  logic [WINDOW_WIDTH:0] r_acc;

  assign o_total = (i_sample && (r_acc != FULL)) ? r_acc + 1'b1 : r_acc;

  // Clearing on capture drops nothing: the capture cycle's sample is in o_total.
  always_ff @(posedge clk) begin
    if (reset)          r_acc <= '0;
    else if (i_capture) r_acc <= '0;
    else                r_acc <= o_total;
  end

endmodule

// File: rtl/seg_pwm_decoder.sv
// Measures per-segment PWM brightness over fixed windows, picks the brightest
// segment and tracks its position along the chase order.
module seg_pwm_decoder
  import seg_pwm_pkg::*;
#(
  parameter int COMMON_ANODE = 1,
  parameter int WINDOW_WIDTH = 8,
  parameter int LEVEL_WIDTH  = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SEGS-1:0]             i_seg_in,
  output logic [NUM_SEGS*LEVEL_WIDTH-1:0] o_level,
  output logic [SEG_W-1:0]                o_peak_seg,
  output logic                            o_peak_valid,
  output logic [STEP_W-1:0]               o_step,
  output logic                            o_direction,
  output logic                            o_locked,
  output logic                            o_frame_valid
);

  localparam int SHIFT = WINDOW_WIDTH - LEVEL_WIDTH;
  localparam logic [NUM_SEGS-1:0] IDLE_PINS =
    (COMMON_ANODE != 0) ? {NUM_SEGS{1'b1}} : {NUM_SEGS{1'b0}};
  localparam logic [WINDOW_WIDTH:0] LEVEL_MAX =
    (WINDOW_WIDTH+1)'((1 << LEVEL_WIDTH) - 1);

  logic [NUM_SEGS-1:0]             r_sync1, r_sync2, w_lit;
  logic [WINDOW_WIDTH-1:0]         r_winCount;
  logic                            w_lastCycle;
  logic [WINDOW_WIDTH:0]           w_total    [NUM_SEGS];
  logic [WINDOW_WIDTH:0]           w_scaled   [NUM_SEGS];
  logic [LEVEL_WIDTH-1:0]          w_newLevel [NUM_SEGS];
  seg_idx_t                        w_peakIdx;
  logic [LEVEL_WIDTH-1:0]          w_peakLevel;
  logic                            w_anyLit;
  logic [NUM_SEGS*LEVEL_WIDTH-1:0] r_level;
  seg_idx_t                        r_peakSeg;
  logic                            r_peakValid, r_trackPending, r_frameValid;
  step_t                           r_step, w_stepNext, w_stepFwd, w_stepBack;
  logic                            r_direction, w_directionNext;
  logic                            r_locked, w_lockedNext;

  // Synchronizer resets to the unlit pin level so a fresh window starts dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= IDLE_PINS;
      r_sync2 <= IDLE_PINS;
    end else begin
      r_sync1 <= i_seg_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lit = (COMMON_ANODE != 0) ? ~r_sync2 : r_sync2;

  always_ff @(posedge clk) begin
    if (reset) r_winCount <= '0;
    else       r_winCount <= r_winCount + 1'b1;
  end

  assign w_lastCycle = &r_winCount;

  for (genvar g = 0; g < NUM_SEGS; g++) begin : g_seg
    seg_duty_counter #(
      .WINDOW_WIDTH(WINDOW_WIDTH)
    ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .i_sample (w_lit[g]),
      .i_capture(w_lastCycle),
      .o_total  (w_total[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_SEGS; i++) begin
      w_scaled[i]   = w_total[i] >> SHIFT;
      w_newLevel[i] = (w_scaled[i] > LEVEL_MAX) ? LEVEL_MAX[LEVEL_WIDTH-1:0]
                                                : w_scaled[i][LEVEL_WIDTH-1:0];
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_peakIdx   = SEG_A;
    w_peakLevel = w_newLevel[0];
    for (int i = 1; i < NUM_SEGS; i++) begin
      if (w_newLevel[i] > w_peakLevel) begin
        w_peakLevel = w_newLevel[i];
        w_peakIdx   = seg_idx_t'(i);
      end
    end
    w_anyLit = (w_peakLevel != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level        <= '0;
      r_peakSeg      <= SEG_A;
      r_peakValid    <= 1'b0;
      r_trackPending <= 1'b0;
      r_frameValid   <= 1'b0;
    end else begin
      r_trackPending <= w_lastCycle;
      r_frameValid   <= r_trackPending;
      if (w_lastCycle) begin
        for (int i = 0; i < NUM_SEGS; i++) begin
          r_level[i*LEVEL_WIDTH +: LEVEL_WIDTH] <= w_newLevel[i];
        end
        r_peakValid <= w_anyLit;
        if (w_anyLit) r_peakSeg <= w_peakIdx;
      end
    end
  end

  assign w_stepFwd  = r_step + 3'd1;
  assign w_stepBack = r_step - 3'd1;

  // The current step always points at the last accepted peak, so a peak equal
  // to chase_seg(r_step) means the brightest segment did not move.
  always_comb begin
    w_stepNext      = r_step;
    w_directionNext = r_direction;
    w_lockedNext    = r_locked;
    if (r_trackPending && r_peakValid && (chase_seg(r_step) != r_peakSeg)) begin
      if (chase_seg(w_stepFwd) == r_peakSeg) begin
        w_stepNext      = w_stepFwd;
        w_directionNext = 1'b1;
        w_lockedNext    = 1'b1;
      end else if (chase_seg(w_stepBack) == r_peakSeg) begin
        w_stepNext      = w_stepBack;
        w_directionNext = 1'b0;
        w_lockedNext    = 1'b1;
      end else begin
        w_stepNext   = first_step_of(r_peakSeg);
        w_lockedNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step      <= '0;
      r_direction <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_step      <= w_stepNext;
      r_direction <= w_directionNext;
      r_locked    <= w_lockedNext;
    end
  end

  assign o_level       = r_level;
  assign o_peak_seg    = r_peakSeg;
  assign o_peak_valid  = r_peakValid;
  assign o_step        = r_step;
  assign o_direction   = r_direction;
  assign o_locked      = r_locked;
  assign o_frame_valid = r_frameValid;

endmodule

// File: tb/tb_seg_pwm_decoder.sv
// Self-checking bench for seg_pwm_decoder (common-anode defaults) against a
// window-level reference model of brightness, peak and chase tracking.
module tb_seg_pwm_decoder;

  localparam int WW   = 8;
  localparam int LW   = 5;
  localparam int WIN  = 1 << WW;
  localparam int LMAX = (1 << LW) - 1;
  localparam logic [6:0] IDLE = 7'h7F;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  i_seg_in;
  logic [34:0] o_level;
  logic [2:0]  o_peak_seg;
  logic        o_peak_valid;
  logic [2:0]  o_step;
  logic        o_direction;
  logic        o_locked;
  logic        o_frame_valid;

  seg_pwm_decoder #(
    .COMMON_ANODE(1),
    .WINDOW_WIDTH(WW),
    .LEVEL_WIDTH (LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_seg_in     (i_seg_in),
    .o_level      (o_level),
    .o_peak_seg   (o_peak_seg),
    .o_peak_valid (o_peak_valid),
    .o_step       (o_step),
    .o_direction  (o_direction),
    .o_locked     (o_locked),
    .o_frame_valid(o_frame_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Chase order: step index -> segment index.
  int chase [8] = '{0, 1, 6, 4, 3, 2, 6, 5};

  // Reference model state, advanced once per rising edge.
  int         mPos;
  int         mCnt [7];
  int         mLvl [7];
  int         mPeak;
  bit         mPeakValid;
  bit         mMoved;
  int         mStep;
  bit         mDir;
  bit         mLock;
  bit         mPending;
  bit         mFrame;
  logic [6:0] mHist [$];

  task automatic model_reset();
    mPos = 0;
    for (int i = 0; i < 7; i++) begin
      mCnt[i] = 0;
      mLvl[i] = 0;
    end
    mPeak = 0; mPeakValid = 0; mMoved = 0;
    mStep = 0; mDir = 0; mLock = 0; mPending = 0; mFrame = 0;
    mHist.delete();
    mHist.push_back(IDLE);
    mHist.push_back(IDLE);
  endtask

  task automatic model_edge(input logic [6:0] pins);
    logic [6:0] s;
    int best, newPeak, fwd, back;
    s = mHist.pop_front();
    mHist.push_back(pins);
    for (int i = 0; i < 7; i++) if (s[i] == 1'b0) mCnt[i]++;
    mFrame = mPending;
    if (mPending && mMoved) begin
      fwd  = (mStep + 1) % 8;
      back = (mStep + 7) % 8;
      if (chase[fwd] == mPeak) begin
        mStep = fwd; mDir = 1; mLock = 1;
      end else if (chase[back] == mPeak) begin
        mStep = back; mDir = 0; mLock = 1;
      end else begin
        mLock = 0;
        for (int k = 7; k >= 0; k--) if (chase[k] == mPeak) mStep = k;
      end
    end
    mPending = 0;
    if (mPos == WIN - 1) begin
      best = 0; newPeak = 0;
      for (int i = 0; i < 7; i++) begin
        mLvl[i] = ((mCnt[i] >> (WW - LW)) > LMAX) ? LMAX : (mCnt[i] >> (WW - LW));
        if (mLvl[i] > best) begin
          best = mLvl[i];
          newPeak = i;
        end
      end
      if (best > 0) begin
        mMoved = (newPeak != mPeak);
        mPeak = newPeak;
        mPeakValid = 1;
      end else begin
        mMoved = 0;
        mPeakValid = 0;
      end
      for (int i = 0; i < 7; i++) mCnt[i] = 0;
      mPending = 1;
    end
    mPos = (mPos + 1) % WIN;
  endtask

  function automatic logic [34:0] model_level_bus();
    logic [34:0] b = '0;
    for (int i = 0; i < 7; i++) b[i*LW +: LW] = LW'(mLvl[i]);
    return b;
  endfunction

  // Pin value whose sample lands at window position (mPos+2): lit while below lowCnt.
  function automatic logic [6:0] pattern_pins(input int lowCnt [7]);
    int land;
    logic [6:0] p;
    land = (mPos + 2) % WIN;
    p = IDLE;
    for (int i = 0; i < 7; i++) if (land < lowCnt[i]) p[i] = 1'b0;
    return p;
  endfunction

  task automatic tick(input logic [6:0] pins, input logic rst);
    i_seg_in = pins;
    reset = rst;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(pins);
    #1;
  endtask

  task automatic run_frames(input int n, input int lowCnt [7]);
    int seen = 0;
    for (int c = 0; c < (n + 1) * WIN && seen < n; c++) begin
      tick(pattern_pins(lowCnt), 1'b0);
      if (mFrame) seen++;
    end
  endtask

  task automatic test_reset();
    tick(IDLE, 1'b1); tick(IDLE, 1'b1); tick(IDLE, 1'b1);
    checks++; if (o_level !== 35'd0) begin failures++; $display("[TB] FAIL reset_level: got %h expected 0", o_level); end
    checks++; if (o_peak_seg !== 3'd0) begin failures++; $display("[TB] FAIL reset_peak_seg: got %0d expected 0", o_peak_seg); end
    checks++; if (o_peak_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_peak_valid: got %0b expected 0", o_peak_valid); end
    checks++; if (o_step !== 3'd0) begin failures++; $display("[TB] FAIL reset_step: got %0d expected 0", o_step); end
    checks++; if ({o_direction, o_locked, o_frame_valid} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags: got %b expected 000", {o_direction, o_locked, o_frame_valid}); end
  endtask

  task automatic test_full_window();
    int lowCnt [7] = '{WIN, 0, 0, 0, 0, 0, 0};
    run_frames(2, lowCnt);
    checks++; if (o_level[0 +: LW] !== 5'd31) begin failures++; $display("[TB] FAIL full_level_a: got %0d expected 31", o_level[0 +: LW]); end
    checks++; if (o_level[34:LW] !== 30'd0) begin failures++; $display("[TB] FAIL full_levels_other: got %h expected 0", o_level[34:LW]); end
    checks++; if (o_peak_seg !== 3'd0 || o_peak_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_peak: got seg %0d valid %0b expected seg 0 valid 1", o_peak_seg, o_peak_valid); end
    checks++; if (o_level !== model_level_bus()) begin failures++; $display("[TB] FAIL full_model_levels: got %h expected %h", o_level, model_level_bus()); end
  endtask

  task automatic test_duty();
    int lowCnt [7];
    int duty   [3] = '{128, 8, 7};
    int expLvl [3] = '{16, 1, 0};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) lowCnt[i] = (i == 3) ? duty[k] : 0;
      run_frames(2, lowCnt);
      checks++; if (o_level[3*LW +: LW] !== 5'(expLvl[k])) begin failures++; $display("[TB] FAIL duty_level_d_%0d: got %0d expected %0d", duty[k], o_level[3*LW +: LW], expLvl[k]); end
      checks++; if (o_level !== model_level_bus() || o_peak_valid !== mPeakValid) begin failures++; $display("[TB] FAIL duty_model_%0d: got %h/%0b expected %h/%0b", duty[k], o_level, o_peak_valid, model_level_bus(), mPeakValid); end
      checks++; if (o_step !== 3'(mStep) || o_locked !== mLock) begin failures++; $display("[TB] FAIL duty_track_%0d: got step %0d lock %0b expected step %0d lock %0b", duty[k], o_step, o_locked, mStep, mLock); end
    end
  endtask

  task automatic test_chase();
    int seq     [10] = '{0, 1, 6, 4, 3, 2, 6, 5, 6, 2};
    int expStep [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5};
    bit expDir  [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit expLock [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int lowCnt [7];
    int sinceFrame;
    bit got;
    tick(IDLE, 1'b1); tick(IDLE, 1'b1);
    sinceFrame = 0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 7; i++) lowCnt[i] = (i == seq[k]) ? WIN : 0;
      got = 0;
      for (int c = 0; c < WIN + 8 && !got; c++) begin
        tick(pattern_pins(lowCnt), 1'b0);
        sinceFrame++;
        checks++; if (o_frame_valid !== mFrame) begin failures++; $display("[TB] FAIL chase_frame_pulse: got %0b expected %0b at window %0d", o_frame_valid, mFrame, k); end
        if (mFrame) got = 1;
      end
      checks++; if (sinceFrame != ((k == 0) ? WIN + 1 : WIN)) begin failures++; $display("[TB] FAIL chase_frame_period: got %0d expected %0d", sinceFrame, (k == 0) ? WIN + 1 : WIN); end
      sinceFrame = 0;
      checks++; if (o_step !== 3'(expStep[k])) begin failures++; $display("[TB] FAIL chase_step_%0d: got %0d expected %0d", k, o_step, expStep[k]); end
      checks++; if (o_direction !== expDir[k] || o_locked !== expLock[k]) begin failures++; $display("[TB] FAIL chase_dirlock_%0d: got %0b%0b expected %0b%0b", k, o_direction, o_locked, expDir[k], expLock[k]); end
      checks++; if (o_peak_seg !== 3'(seq[k])) begin failures++; $display("[TB] FAIL chase_peak_%0d: got %0d expected %0d", k, o_peak_seg, seq[k]); end
    end
  endtask

  task automatic test_jump();
    int seq     [6] = '{3, 4, 6, 1, 0, 3};
    int expStep [6] = '{4, 3, 2, 1, 0, 4};
    bit expLock [6] = '{1, 1, 1, 1, 1, 0};
    int lowCnt [7];
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 7; i++) lowCnt[i] = (i == seq[k]) ? WIN : 0;
      run_frames(1, lowCnt);
      checks++; if (o_step !== 3'(expStep[k]) || o_locked !== expLock[k] || o_direction !== 1'b0) begin failures++; $display("[TB] FAIL jump_track_%0d: got step %0d lock %0b dir %0b expected step %0d lock %0b dir 0", k, o_step, o_locked, o_direction, expStep[k], expLock[k]); end
    end
    lowCnt = '{0, 0, 160, 0, 0, 160, 0};
    run_frames(2, lowCnt);
    checks++; if (o_level[2*LW +: LW] !== 5'd20 || o_level[5*LW +: LW] !== 5'd20) begin failures++; $display("[TB] FAIL tie_levels: got %0d,%0d expected 20,20", o_level[2*LW +: LW], o_level[5*LW +: LW]); end
    checks++; if (o_peak_seg !== 3'd2) begin failures++; $display("[TB] FAIL tie_peak: got %0d expected 2", o_peak_seg); end
    checks++; if (o_step !== 3'd5 || o_direction !== 1'b1 || o_locked !== 1'b1) begin failures++; $display("[TB] FAIL tie_track: got step %0d dir %0b lock %0b expected 5 1 1", o_step, o_direction, o_locked); end
  endtask

  task automatic test_random();
    int duty [7];
    logic [6:0] pins;
    bit got;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 7; i++) duty[i] = (f == 3) ? 0 : int'($urandom_range(0, WIN));
      got = 0;
      for (int c = 0; c < 2 * WIN && !got; c++) begin
        pins = IDLE;
        for (int i = 0; i < 7; i++) if (int'($urandom_range(0, WIN - 1)) < duty[i]) pins[i] = 1'b0;
        tick(pins, 1'b0);
        if (mFrame) got = 1;
      end
      checks++; if (o_frame_valid !== 1'b1) begin failures++; $display("[TB] FAIL rand_frame_%0d: got %0b expected 1", f, o_frame_valid); end
      checks++; if (o_level !== model_level_bus()) begin failures++; $display("[TB] FAIL rand_levels_%0d: got %h expected %h", f, o_level, model_level_bus()); end
      checks++; if (o_peak_seg !== 3'(mPeak) || o_peak_valid !== mPeakValid) begin failures++; $display("[TB] FAIL rand_peak_%0d: got %0d/%0b expected %0d/%0b", f, o_peak_seg, o_peak_valid, mPeak, mPeakValid); end
      checks++; if (o_step !== 3'(mStep) || o_direction !== mDir || o_locked !== mLock) begin failures++; $display("[TB] FAIL rand_track_%0d: got %0d %0b %0b expected %0d %0b %0b", f, o_step, o_direction, o_locked, mStep, mDir, mLock); end
      if (f == 3) begin
        checks++; if (o_peak_valid !== 1'b0) begin failures++; $display("[TB] FAIL dark_peak_valid: got %0b expected 0", o_peak_valid); end
      end
    end
  endtask

  task automatic test_reset_midwindow();
    int lowCnt [7] = '{WIN, WIN, WIN, WIN, WIN, WIN, WIN};
    int first = 0;
    run_frames(1, lowCnt);
    for (int c = 0; c < WIN && mPos != 100; c++) tick(pattern_pins(lowCnt), 1'b0);
    tick(pattern_pins(lowCnt), 1'b1);
    checks++; if (o_level !== 35'd0 || o_peak_seg !== 3'd0 || o_peak_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_levels: got %h/%0d/%0b expected 0/0/0", o_level, o_peak_seg, o_peak_valid); end
    checks++; if (o_step !== 3'd0 || {o_direction, o_locked, o_frame_valid} !== 3'b000) begin failures++; $display("[TB] FAIL midreset_track: got %0d/%b expected 0/000", o_step, {o_direction, o_locked, o_frame_valid}); end
    for (int n = 1; n <= 300 && first == 0; n++) begin
      tick(pattern_pins(lowCnt), 1'b0);
      if (o_frame_valid === 1'b1) first = n;
    end
    checks++; if (first != WIN + 1) begin failures++; $display("[TB] FAIL midreset_first_frame: got %0d expected %0d", first, WIN + 1); end
    checks++; if (o_level[0 +: LW] !== 5'd31) begin failures++; $display("[TB] FAIL midreset_new_level: got %0d expected 31", o_level[0 +: LW]); end
  endtask

  initial begin
    reset = 1'b1;
    i_seg_in = IDLE;
    model_reset();
    test_reset();
    test_full_window();
    test_duty();
    test_chase();
    test_jump();
    test_random();
    test_reset_midwindow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/seg_pwm_decoder.md
SEG_PWM_DECODER -- requirements
Module: seg_pwm_decoder

Interface
REQ-001 Parameter COMMON_ANODE, default 1; 1 = segment inputs active-low (lit = 0), 0 = active-high.
REQ-002 Parameter WINDOW_WIDTH, default 8; measurement window = 2^WINDOW_WIDTH clk cycles.
REQ-003 Parameter LEVEL_WIDTH, default 5; brightness resolution per segment; SHALL satisfy LEVEL_WIDTH <= WINDOW_WIDTH.
REQ-004 Clock and reset: reset reset, synchronous, active-high; clock clk.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 seg_in  input  7  segment drive lines a..g (bit0 = a ... bit6 = g), asynchronous to clk.
REQ-008 level  output  7*LEVEL_WIDTH  per-segment brightness; segment i occupies bits [i*LEVEL_WIDTH +: LEVEL_WIDTH].
REQ-009 peak_seg  output  3  index of the brightest segment in the last window.
REQ-010 peak_valid  output  1  1 when at least one level is nonzero.
REQ-011 step  output  3  decoded chase position 0..7.
REQ-012 direction  output  1  1 = forward chase, 0 = reverse.
REQ-013 locked  output  1  1 when the last peak move was consistent with the chase order.
REQ-014 frame_valid  output  1  one-cycle pulse; all outputs updated and coherent.

Function
REQ-015 seg_in SHALL pass through a 2-flop synchronizer, then be normalised to lit = 1 (inverted when COMMON_ANODE = 1).
REQ-016 Window counter SHALL count 0..2^WINDOW_WIDTH-1 and wrap; each cycle every segment accumulator SHALL increment when its normalised sample is 1.
REQ-017 Accumulators SHALL be WINDOW_WIDTH+1 bits wide (range 0..2^WINDOW_WIDTH) and SHALL never wrap.
REQ-018 On the last window cycle (cycle E), with that cycle's sample included, level_i SHALL be registered as min(count_i >> (WINDOW_WIDTH-LEVEL_WIDTH), 2^LEVEL_WIDTH-1), and accumulators SHALL clear for the next window without losing a sample.
REQ-019 At E, peak_seg SHALL register the index of the maximum level, with ties resolved to the lowest index; when all levels are 0, peak_valid = 0 and peak_seg holds its previous value.
REQ-020 Chase table (step -> segment): 0->0, 1->1, 2->6, 3->4, 4->3, 5->2, 6->6, 7->5.
REQ-021 Tracker SHALL update at E+1 from the peak registered at E:
  - peak_valid = 0 or peak unchanged: no change.
  - peak = table[step+1 mod 8]: step+1, direction = 1, locked = 1.
  - peak = table[step-1 mod 8]: step-1, direction = 0, locked = 1.
  - otherwise: locked = 0, step = lowest table index mapping to the peak (g -> 2), direction unchanged.
REQ-022 frame_valid SHALL pulse high for exactly one cycle at E+1; pin-to-accumulator latency is 2 cycles.
REQ-023 step arithmetic SHALL wrap modulo 8 (7+1 = 0, 0-1 = 7).

Reset
REQ-024 Reset SHALL clear the synchronizer, window counter and all accumulators, and set level = 0, peak_seg = 0, peak_valid = 0, step = 0, direction = 0, locked = 0, frame_valid = 0.
REQ-025 Reset asserted mid-window SHALL discard the partial window; the first frame_valid after release occurs 2^WINDOW_WIDTH+1 cycles after the first non-reset edge.

Structure
REQ-026 Package seg_pwm_pkg SHALL hold the chase table, the segment-index constants and the step/segment widths.
REQ-027 One sub-module, seg_duty_counter (a saturating per-segment accumulator with a clear-and-capture port), SHALL be instantiated 7 times via generate.

Verification
REQ-028 Defaults, CA; seg_in[0] held 0 and others held 1 for a full window -> level[0] = 31, other levels = 0, peak_seg = 0, peak_valid = 1.
REQ-029 seg_in[3] low for 128 of 256 cycles -> level[3] = 16; 8 of 256 cycles -> level[3] = 1; 7 of 256 cycles -> level[3] = 0.
REQ-030 Full-brightness peak sequence a, b, g, e, one window each -> step 0, 1, 2, 3, direction = 1, locked = 1, frame_valid pulsing once per 256 cycles.
REQ-031 Reach step 7 (f), then peak g -> step 6, direction = 0, locked = 1; then peak c -> step 5.
REQ-032 At step 0, peak jumps to d -> locked = 0, step = 4; levels 20 on segments 2 and 5 -> peak_seg = 2.
REQ-033 Reset asserted at window cycle 100 -> all outputs 0 next cycle, and no frame_valid until 257 cycles after release.
